// File: rtl/shift_cam_fifo.sv
// Shift-register FIFO with per-slot valid bits and associative compare ports.
// Slot 0 always holds the oldest entry. Each compare port reports a per-slot
// hit vector, an any-hit flag and the index of the oldest hit.
module shift_cam_fifo #(
    parameter int W_WRITE       = 32,
    parameter int W_COMPARE     = W_WRITE,
    parameter int P_COMPSBIT    = 0,
    parameter int C_NUMBERWORDS = 8,
    parameter int C_NUMCOMPARE  = 2,
    parameter int P_REGRESULT   = 1,
    localparam int LW_ADDRESS   = $clog2(C_NUMBERWORDS),
    localparam int LW_COUNT     = $clog2(C_NUMBERWORDS + 1)
) (
    input  logic                                  sClk_i,
    input  logic                                  sRst_i,
    input  logic                                  Flush_i,
    input  logic                                  Write_i,
    input  logic [W_WRITE-1:0]                    WriteData_i,
    input  logic                                  Read_i,
    output logic [W_WRITE-1:0]                    ReadData_oc,
    output logic                                  Empty_oc,
    output logic                                  Full_oc,
    output logic [LW_COUNT-1:0]                   Count_o,
    input  logic [C_NUMCOMPARE*W_COMPARE-1:0]     CompareData_i,
    input  logic [C_NUMCOMPARE-1:0]               CompareEn_i,
    output logic [C_NUMCOMPARE*C_NUMBERWORDS-1:0] CompareResult_o,
    output logic [C_NUMCOMPARE-1:0]               CompareAny_o,
    output logic [C_NUMCOMPARE*LW_ADDRESS-1:0]    CompareFirst_o
);

    logic [W_WRITE-1:0]       slot_q [C_NUMBERWORDS];
    logic [W_WRITE-1:0]       slot_d [C_NUMBERWORDS];
    logic [C_NUMBERWORDS-1:0] valid_q, valid_d;
    logic [LW_COUNT-1:0]      count_q, count_d;
    logic                     empty_q, full_q;

    logic                     read_en, write_en;
    logic [LW_COUNT-1:0]      wr_idx;

    logic [C_NUMCOMPARE*C_NUMBERWORDS-1:0] res_c;
    logic [C_NUMCOMPARE-1:0]               any_c;
    logic [C_NUMCOMPARE*LW_ADDRESS-1:0]    first_c;

    assign read_en  = Read_i & ~empty_q;
    assign write_en = Write_i & (~full_q | read_en);
    // A push that coincides with a pop lands in the slot vacated by the shift.
    assign wr_idx   = read_en ? count_q - 1'b1 : count_q;

    // Next slot contents, valid bits and occupancy.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        slot_d  = slot_q;
        valid_d = valid_q;
        count_d = count_q;
        if (Flush_i) begin
            for (int i = 0; i < C_NUMBERWORDS; i++) slot_d[i] = '0;
            valid_d = '0;
            count_d = '0;
        end else begin
            // Unused slots are held at zero, so shifting the whole array clears slot Count-1.
            if (read_en) begin
                for (int i = 0; i < C_NUMBERWORDS - 1; i++) slot_d[i] = slot_q[i+1];
                slot_d[C_NUMBERWORDS-1] = '0;
                valid_d = {1'b0, valid_q[C_NUMBERWORDS-1:1]};
            end
            if (write_en) begin
                for (int i = 0; i < C_NUMBERWORDS; i++) begin
                    if (wr_idx == LW_COUNT'(i)) begin
                        slot_d[i]  = WriteData_i;
                        valid_d[i] = 1'b1;
                    end
                end
            end
            if (read_en && !write_en)      count_d = count_q - 1'b1;
            else if (write_en && !read_en) count_d = count_q + 1'b1;
        end
    end

    // State register; flags are registered alongside the count so they always agree.
    always_ff @(posedge sClk_i) begin
        // NOTE: data slots are reset too: the read port must show 0 when empty and stale data must never hit.
        if (sRst_i) begin
            for (int i = 0; i < C_NUMBERWORDS; i++) slot_q[i] <= '0;
            valid_q <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            slot_q  <= slot_d;
            valid_q <= valid_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == LW_COUNT'(C_NUMBERWORDS));
        end
    end

    assign ReadData_oc = slot_q[0];
    assign Empty_oc    = empty_q;
    assign Full_oc     = full_q;
    assign Count_o     = count_q;

    // Associative compare of every valid slot against each port key, plus oldest-hit encoding.
    always_comb begin
        res_c   = '0;
        any_c   = '0;
        first_c = '0;
        for (int p = 0; p < C_NUMCOMPARE; p++) begin
            for (int i = 0; i < C_NUMBERWORDS; i++) begin
                res_c[p*C_NUMBERWORDS + i] = CompareEn_i[p] & valid_q[i] &
                    (slot_q[i][P_COMPSBIT +: W_COMPARE] == CompareData_i[p*W_COMPARE +: W_COMPARE]);
            end
            any_c[p] = |res_c[p*C_NUMBERWORDS +: C_NUMBERWORDS];
            // Scan downwards so the lowest (oldest) hit index is the one left standing.
            for (int i = C_NUMBERWORDS - 1; i >= 0; i--) begin
                if (res_c[p*C_NUMBERWORDS + i]) first_c[p*LW_ADDRESS +: LW_ADDRESS] = LW_ADDRESS'(i);
            end
        end
    end

    if (P_REGRESULT != 0) begin : g_reg_result
        // Registered results reflect contents before this edge's push/pop/flush.
        always_ff @(posedge sClk_i) begin
            if (sRst_i) begin
                CompareResult_o <= '0;
                CompareAny_o    <= '0;
                CompareFirst_o  <= '0;
            end else begin
                CompareResult_o <= res_c;
                CompareAny_o    <= any_c;
                CompareFirst_o  <= first_c;
            end
        end
    end else begin : g_comb_result
        assign CompareResult_o = res_c;
        assign CompareAny_o    = any_c;
        assign CompareFirst_o  = first_c;
    end

endmodule

// File: tb/tb_shift_cam_fifo.sv
// Self-checking bench for shift_cam_fifo (default parameters, registered compare results).
// A queue-based model tracks FIFO contents; compare expectations are computed from it.
module tb_shift_cam_fifo;

    localparam int N  = 8;
    localparam int NC = 2;
    localparam int W  = 32;
    localparam int LA = 3;
    localparam int LC = 4;

    logic            clk = 1'b0;
    logic            rst, flush, wr, rd;
    logic [W-1:0]    wdata;
    logic [W-1:0]    rdata;
    logic            empty, full;
    logic [LC-1:0]   count;
    logic [NC*W-1:0] cmp_data;
    logic [NC-1:0]   cmp_en;
    logic [NC*N-1:0] cmp_res;
    logic [NC-1:0]   cmp_any;
    logic [NC*LA-1:0] cmp_first;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]     model[$];
    logic [NC*N-1:0]  exp_res;
    logic [NC-1:0]    exp_any;
    logic [NC*LA-1:0] exp_first;

    always #5 clk = ~clk;

    shift_cam_fifo dut (
        .sClk_i          (clk),
        .sRst_i          (rst),
        .Flush_i         (flush),
        .Write_i         (wr),
        .WriteData_i     (wdata),
        .Read_i          (rd),
        .ReadData_oc     (rdata),
        .Empty_oc        (empty),
        .Full_oc         (full),
        .Count_o         (count),
        .CompareData_i   (cmp_data),
        .CompareEn_i     (cmp_en),
        .CompareResult_o (cmp_res),
        .CompareAny_o    (cmp_any),
        .CompareFirst_o  (cmp_first)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected hits from the model's current contents: slot i is entry i of the queue.
    function automatic void model_compare(input logic [W-1:0] k0, input logic [W-1:0] k1,
                                          input logic [1:0] en);
        logic [N-1:0]  hits;
        logic [LA-1:0] first;
        logic [W-1:0]  key;
        exp_res   = '0;
        exp_any   = '0;
        exp_first = '0;
        for (int p = 0; p < NC; p++) begin
            key   = (p == 0) ? k0 : k1;
            hits  = '0;
            first = '0;
            for (int i = 0; i < model.size(); i++)
                if (en[p] && model[i] == key) hits[i] = 1'b1;
            for (int i = 0; i < N; i++)
                if (hits[i]) begin
                    first = LA'(i);
                    break;
                end
            exp_res[p*N +: N]    = hits;
            exp_any[p]           = |hits;
            exp_first[p*LA +: LA] = first;
        end
    endfunction

    // One clock cycle: drive inputs, advance the model, check all outputs #1 after the edge.
    task automatic step(input logic r, input logic f, input logic w, input logic [W-1:0] wd,
                        input logic rq, input logic [W-1:0] k0, input logic [W-1:0] k1,
                        input logic [1:0] en);
        logic can_rd, can_wr;
        rst = r; flush = f; wr = w; wdata = wd; rd = rq;
        cmp_data = {k1, k0};
        cmp_en   = en;
        model_compare(k0, k1, en);
        @(posedge clk);
        #1;
        if (r) begin
            model.delete();
            exp_res = '0; exp_any = '0; exp_first = '0;
        end else if (f) begin
            model.delete();
        end else begin
            can_rd = rq && (model.size() > 0);
            can_wr = w && (model.size() < N || can_rd);
            if (can_rd) void'(model.pop_front());
            if (can_wr) model.push_back(wd);
        end
        chk("count", 64'(count), 64'(model.size()));
        chk("empty", 64'(empty), 64'(model.size() == 0));
        chk("full",  64'(full),  64'(model.size() == N));
        chk("rdata", 64'(rdata), (model.size() > 0) ? 64'(model[0]) : 64'd0);
        chk("cmp_res",   64'(cmp_res),   64'(exp_res));
        chk("cmp_any",   64'(cmp_any),   64'(exp_any));
        chk("cmp_first", 64'(cmp_first), 64'(exp_first));
    endtask

    task automatic push(input logic [W-1:0] d);
        step(0, 0, 1, d, 0, 0, 0, 2'b00);
    endtask

    task automatic pop();
        step(0, 0, 0, 0, 1, 0, 0, 2'b00);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
        cmp_data = '0; cmp_en = '0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("reset_empty", 64'(empty), 64'd1);

        // Fill to full, drop the 9th push, drain in order
        for (int i = 1; i <= N; i++) push(32'h11 * i);
        chk("t2_full", 64'(full), 64'd1);
        push(32'h99);
        chk("t2_drop_count", 64'(count), 64'd8);
        for (int i = 1; i <= N; i++) begin
            chk("t2_pop_data", 64'(rdata), 64'(32'h11 * i));
            pop();
        end
        chk("t2_empty", 64'(empty), 64'd1);
        pop();  // read on empty is ignored

        // Push+pop while full
        for (int i = 1; i <= N; i++) push(32'h11 * i);
        step(0, 0, 1, 32'h99, 1, 0, 0, 2'b00);
        chk("t3_rdata", 64'(rdata), 64'h22);
        chk("t3_count", 64'(count), 64'd8);
        for (int i = 0; i < N - 1; i++) pop();
        chk("t3_slot7", 64'(rdata), 64'h99);

        // Write on empty with read: write wins
        pop();
        step(0, 0, 1, 32'h5A, 1, 0, 0, 2'b00);
        chk("wr_on_empty_count", 64'(count), 64'd1);

        // Reset mid-operation with 5 entries
        for (int i = 0; i < 4; i++) push(32'h30 + i);
        chk("t1_pre_count", 64'(count), 64'd5);
        step(1, 0, 1, 32'h77, 1, 32'h5A, 32'h30, 2'b11);
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_cmp", 64'(cmp_res), 64'd0);

        // Compare with hits on slots 0 and 2
        push(32'hA); push(32'hB); push(32'hA);
        step(0, 0, 0, 0, 0, 32'hA, 32'hC, 2'b11);
        chk("t4_hit0",   64'(cmp_res[7:0]),  64'h05);
        chk("t4_hit1",   64'(cmp_res[15:8]), 64'h00);
        chk("t4_any",    64'(cmp_any),       64'b01);
        chk("t4_first0", 64'(cmp_first[2:0]), 64'd0);

        // Pop, then the remaining 0xA sits in slot 1
        step(0, 0, 0, 0, 1, 32'hA, 32'hC, 2'b11);
        step(0, 0, 0, 0, 0, 32'hA, 32'hC, 2'b11);
        chk("t5_hit0",   64'(cmp_res[7:0]),   64'h02);
        chk("t5_first0", 64'(cmp_first[2:0]), 64'd1);

        // Flush with a write on 3 entries
        push(32'hA);
        chk("t6_pre_count", 64'(count), 64'd3);
        step(0, 1, 1, 32'hA, 0, 32'hA, 32'hB, 2'b11);
        chk("t6_count", 64'(count), 64'd0);
        step(0, 0, 0, 0, 0, 32'hA, 32'hB, 2'b11);
        chk("t6_cmp", 64'(cmp_res), 64'd0);

        // Randomized traffic with a small value range so keys collide often
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 9) < 6), 32'($urandom_range(0, 5)),
                 ($urandom_range(0, 9) < 4),
                 32'($urandom_range(0, 5)), 32'($urandom_range(0, 5)),
                 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
